// File: rtl/inst_enc_pkg.sv
// ---------------------------------------------------------------------------
// inst_enc_pkg
// Shared constants for the RV32I instruction encoder: register/word widths,
// the decoder's instruction-class encodings, opcodes, funct3 values, the NOP
// word and the signed immediate ranges each format can carry.
// ---------------------------------------------------------------------------
package inst_enc_pkg;

    localparam int REG_END_ID    = 4;
    localparam int REG_END_WORD  = 31;
    localparam int INST_TYPE_END = 4;

    // Instruction classes as produced by the core decoder. LOAD and STORE
    // carry the access size in the low two bits, SYSTEM carries funct3 in
    // the low three bits, so those are wildcard patterns for casez.
    localparam logic [INST_TYPE_END:0] INST_IMM    = 5'b00001;
    localparam logic [INST_TYPE_END:0] INST_REG    = 5'b00010;
    localparam logic [INST_TYPE_END:0] INST_UPP    = 5'b00011;
    localparam logic [INST_TYPE_END:0] INST_JUMP   = 5'b00100;
    localparam logic [INST_TYPE_END:0] INST_JUMPR  = 5'b00101;
    localparam logic [INST_TYPE_END:0] INST_BRANCH = 5'b00110;
    localparam logic [INST_TYPE_END:0] INST_LOAD   = 5'b010??;
    localparam logic [INST_TYPE_END:0] INST_STORE  = 5'b011??;
    localparam logic [INST_TYPE_END:0] INST_SYSTEM = 5'b10???;

    typedef enum logic [6:0] {
        OPCODE_LOAD   = 7'b0000011,
        OPCODE_IMM    = 7'b0010011,
        OPCODE_STORE  = 7'b0100011,
        OPCODE_REG    = 7'b0110011,
        OPCODE_LUI    = 7'b0110111,
        OPCODE_BRANCH = 7'b1100011,
        OPCODE_JALR   = 7'b1100111,
        OPCODE_JAL    = 7'b1101111,
        OPCODE_SYSTEM = 7'b1110011
    } opcode_e;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_SYS0 = 3'b000;
    localparam logic [2:0] FUNCT3_SYS4 = 3'b100;

    localparam logic [2:0] COM_OP_RSVD2 = 3'b010;
    localparam logic [2:0] COM_OP_RSVD3 = 3'b011;

    localparam logic [1:0] MEM_SZ_WORD = 2'b10;
    localparam logic [1:0] MEM_SZ_RSVD = 2'b11;

    // addi x0, x0, 0 -- substituted for anything that cannot be encoded
    localparam logic [REG_END_WORD:0] INST_NOP = 32'h0000_0013;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4095;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048575;

    // True when the sign-extended immediate lies inside [lo, hi].
    function automatic logic immInRange(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// ---------------------------------------------------------------------------
// inst_fifo
// Synchronous DEPTH-entry FIFO built as a shift register so the head is
// always a flop (r_mem[0]) and resets to zero.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   i_push, i_data   write request and data (ignored when full)
//   i_pop            remove head (ignored when empty)
//   o_head           registered head entry
//   o_full, o_empty  occupancy flags
// ---------------------------------------------------------------------------
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_wrIdx;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    // Fullness is judged before the pop, so a pop never makes room for a
    // push in the same cycle.
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & ~o_full;

    // When popping, the tail slides down one place before the write lands.
    assign w_wrIdx = w_pop ? (r_count - CW'(1)) : r_count;

    // Shift on pop, then write the new entry behind the last valid one; the
    // later non-blocking write wins where both touch the same slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
                r_mem[DEPTH-1] <= '0;
            end
            if (w_push) begin
                r_mem[w_wrIdx[CW-2:0]] <= i_data;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head = r_mem[0];

endmodule

// File: rtl/inst_enc.sv
// ---------------------------------------------------------------------------
// inst_enc
// RV32I instruction encoder. Packs decoded instruction fields into 32-bit
// words, flags unencodable tuples (emitting a NOP for them) and buffers the
// results in a small output FIFO.
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   in_valid / in_ready     field tuple handshake
//   in_type ... in_mem_sign decoded fields
//   out_valid / out_ready   FIFO head handshake
//   out_inst, out_err       registered head word and error flag
//   enc_count, err_count    wrapping counts of accepted / errored tuples
// ---------------------------------------------------------------------------
module inst_enc
    import inst_enc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INST_TYPE_END:0]  in_type,
    input  logic [REG_END_ID:0]     in_rd,
    input  logic [REG_END_ID:0]     in_rs1,
    input  logic [REG_END_ID:0]     in_rs2,
    input  logic [REG_END_WORD:0]   in_imm,
    input  logic [3:0]              in_alu_op,
    input  logic [2:0]              in_com_op,
    input  logic                    in_mem_sign,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [REG_END_WORD:0]   out_inst,
    output logic                    out_err,
    output logic [CNT_W-1:0]        enc_count,
    output logic [CNT_W-1:0]        err_count
);

    logic [REG_END_WORD:0] w_rawInst;
    logic [REG_END_WORD:0] w_encInst;
    logic                  w_err;
    logic [2:0]            w_f3;
    logic [1:0]            w_memSz;
    logic                  w_isShift;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_empty;
    logic [REG_END_WORD+1:0] w_fifoHead;
    logic                  r_live;
    logic [CNT_W-1:0]      r_encCount;
    logic [CNT_W-1:0]      r_errCount;

    assign w_f3      = in_alu_op[2:0];
    assign w_memSz   = in_type[1:0];
    assign w_isShift = (w_f3 == FUNCT3_SLL) || (w_f3 == FUNCT3_SR);

    // Format packing and legality checks for every instruction class.
    always_comb begin
        w_rawInst = '0;
        w_err     = 1'b0;
        casez (in_type)
            INST_IMM: begin
                if (w_isShift) begin
                    w_rawInst = {1'b0, in_alu_op[3], 5'b0, in_imm[4:0], in_rs1, w_f3, in_rd, OPCODE_IMM};
                    w_err     = |in_imm[31:5];
                end else begin
                    w_rawInst = {in_imm[11:0], in_rs1, w_f3, in_rd, OPCODE_IMM};
                    w_err     = !immInRange(in_imm, IMM_I_MIN, IMM_I_MAX);
                end
                // Only SRAI may carry the alternate-op bit
                if (in_alu_op[3] && (w_f3 != FUNCT3_SR)) begin
                    w_err = 1'b1;
                end
            end
            INST_REG: begin
                w_rawInst = {1'b0, in_alu_op[3], 5'b0, in_rs2, in_rs1, w_f3, in_rd, OPCODE_REG};
                w_err     = in_alu_op[3] && (w_f3 != FUNCT3_ADD) && (w_f3 != FUNCT3_SR);
            end
            INST_LOAD: begin
                // funct3 high bit is the "unsigned" flag; LWU does not exist in RV32I
                w_rawInst = {in_imm[11:0], in_rs1, ~in_mem_sign, w_memSz, in_rd, OPCODE_LOAD};
                w_err     = (w_memSz == MEM_SZ_RSVD)
                          || ((w_memSz == MEM_SZ_WORD) && !in_mem_sign)
                          || !immInRange(in_imm, IMM_I_MIN, IMM_I_MAX);
            end
            INST_STORE: begin
                w_rawInst = {in_imm[11:5], in_rs2, in_rs1, 1'b0, w_memSz, in_imm[4:0], OPCODE_STORE};
                w_err     = (w_memSz == MEM_SZ_RSVD) || !immInRange(in_imm, IMM_I_MIN, IMM_I_MAX);
            end
            INST_UPP: begin
                w_rawInst = {in_imm[31:12], in_rd, OPCODE_LUI};
                w_err     = |in_imm[11:0];
            end
            INST_JUMP: begin
                w_rawInst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPCODE_JAL};
                w_err     = in_imm[0] || !immInRange(in_imm, IMM_J_MIN, IMM_J_MAX);
            end
            INST_JUMPR: begin
                w_rawInst = {in_imm[11:0], in_rs1, FUNCT3_ADD, in_rd, OPCODE_JALR};
                w_err     = !immInRange(in_imm, IMM_I_MIN, IMM_I_MAX);
            end
            INST_BRANCH: begin
                w_rawInst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_com_op,
                             in_imm[4:1], in_imm[11], OPCODE_BRANCH};
                w_err     = (in_com_op == COM_OP_RSVD2) || (in_com_op == COM_OP_RSVD3)
                          || in_imm[0] || !immInRange(in_imm, IMM_B_MIN, IMM_B_MAX);
            end
            INST_SYSTEM: begin
                // Immediate field holds the CSR address, so no range check
                w_rawInst = {in_imm[11:0], in_rs1, in_type[2:0], in_rd, OPCODE_SYSTEM};
                w_err     = (in_type[2:0] == FUNCT3_SYS0) || (in_type[2:0] == FUNCT3_SYS4);
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    assign w_encInst = w_err ? INST_NOP : w_rawInst;

    // Holds in_ready low through reset and releases it on the first clock
    // after reset_n rises.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign in_ready = r_live & ~w_full;
    assign w_accept = in_valid & in_ready;

    // Wrapping tallies of accepted and errored tuples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_encCount <= '0;
            r_errCount <= '0;
        end else if (w_accept) begin
            r_encCount <= r_encCount + CNT_W'(1);
            if (w_err) begin
                r_errCount <= r_errCount + CNT_W'(1);
            end
        end
    end

    inst_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(REG_END_WORD + 2)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_accept),
        .i_pop   (out_ready),
        .i_data  ({w_err, w_encInst}),
        .o_head  (w_fifoHead),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = ~w_empty;
    assign out_inst  = w_fifoHead[REG_END_WORD:0];
    assign out_err   = w_fifoHead[REG_END_WORD+1];
    assign enc_count = r_encCount;
    assign err_count = r_errCount;

endmodule

// File: tb/tb_inst_enc.sv
// ---------------------------------------------------------------------------
// tb_inst_enc
// Scoreboard bench for inst_enc: a stimulus process pushes the reference
// encoding of every accepted tuple into a queue; a monitor process compares
// the FIFO head against the queue front each cycle and pops on transfer.
// ---------------------------------------------------------------------------
module tb_inst_enc;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    localparam logic [4:0] T_IMM    = 5'd1;
    localparam logic [4:0] T_REG    = 5'd2;
    localparam logic [4:0] T_UPP    = 5'd3;
    localparam logic [4:0] T_JUMP   = 5'd4;
    localparam logic [4:0] T_JUMPR  = 5'd5;
    localparam logic [4:0] T_BRANCH = 5'd6;

    typedef struct {
        logic [4:0]  ty;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [2:0]  com;
        logic        sign;
    } tuple_t;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       in_type = '0;
    logic [4:0]       in_rd = '0;
    logic [4:0]       in_rs1 = '0;
    logic [4:0]       in_rs2 = '0;
    logic [31:0]      in_imm = '0;
    logic [3:0]       in_alu_op = '0;
    logic [2:0]       in_com_op = '0;
    logic             in_mem_sign = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_inst;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    logic [32:0] expQ[$];
    int vectorCount = 0;
    int missCount = 0;
    int modelEnc = 0;
    int modelErr = 0;
    int readyMode = 0;

    always #5 clock = ~clock;

    inst_enc #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_type     (in_type),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .in_alu_op   (in_alu_op),
        .in_com_op   (in_com_op),
        .in_mem_sign (in_mem_sign),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_err     (out_err),
        .enc_count   (enc_count),
        .err_count   (err_count)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] iWord(input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [31:0] op);
        return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    endfunction

    // Reference encoder: returns {err, word} from the RV32I field layouts.
    function automatic logic [32:0] refEncode(input tuple_t t);
        logic [31:0] imm;
        logic [31:0] rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] f3;
        logic [31:0] sz;
        logic [31:0] w;
        int s;
        bit bad;
        imm = t.imm;
        s   = $signed(t.imm);
        rd  = 32'(t.rd);
        rs1 = 32'(t.rs1);
        rs2 = 32'(t.rs2);
        f3  = 32'(t.alu[2:0]);
        sz  = 32'(t.ty[1:0]);
        w   = '0;
        bad = 1'b0;
        if (t.ty == T_IMM) begin
            if (f3 == 1 || f3 == 5) begin
                bad = (imm >> 5) != 0;
                w = iWord((t.alu[3] ? 32'h400 : 32'h0) | (imm & 31), rs1, f3, rd, 32'h13);
            end else begin
                bad = (s < -2048) || (s > 2047);
                w = iWord(imm, rs1, f3, rd, 32'h13);
            end
            if (t.alu[3] && f3 != 5) bad = 1'b1;
        end else if (t.ty == T_REG) begin
            bad = t.alu[3] && !(f3 == 0 || f3 == 5);
            w = (t.alu[3] ? 32'h4000_0000 : 32'h0) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
        end else if (t.ty[4:2] == 3'b010) begin
            bad = (sz == 3) || (sz == 2 && !t.sign) || (s < -2048) || (s > 2047);
            w = iWord(imm, rs1, (t.sign ? 32'd0 : 32'd4) + sz, rd, 32'h03);
        end else if (t.ty[4:2] == 3'b011) begin
            bad = (sz == 3) || (s < -2048) || (s > 2047);
            w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (sz << 12) | ((imm & 31) << 7) | 32'h23;
        end else if (t.ty == T_UPP) begin
            bad = (imm & 32'hFFF) != 0;
            w = (imm & 32'hFFFF_F000) | (rd << 7) | 32'h37;
        end else if (t.ty == T_JUMP) begin
            bad = imm[0] || (s < -1048576) || (s > 1048575);
            w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20)
              | (((imm >> 12) & 255) << 12) | (rd << 7) | 32'h6F;
        end else if (t.ty == T_JUMPR) begin
            bad = (s < -2048) || (s > 2047);
            w = iWord(imm, rs1, 0, rd, 32'h67);
        end else if (t.ty == T_BRANCH) begin
            bad = (t.com == 3'd2) || (t.com == 3'd3) || imm[0] || (s < -4096) || (s > 4095);
            w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
              | (32'(t.com) << 12) | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
        end else if (t.ty[4:3] == 2'b10) begin
            bad = (t.ty[2:0] == 3'd0) || (t.ty[2:0] == 3'd4);
            w = iWord(imm, rs1, 32'(t.ty[2:0]), rd, 32'h73);
        end else begin
            bad = 1'b1;
        end
        return bad ? {1'b1, 32'h0000_0013} : {1'b0, w};
    endfunction

    function automatic tuple_t mk(input logic [4:0] ty, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm, input logic [3:0] alu,
                                  input logic [2:0] com, input logic sign);
        tuple_t t;
        t.ty = ty; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
        t.imm = imm; t.alu = alu; t.com = com; t.sign = sign;
        return t;
    endfunction

    function automatic tuple_t randTuple();
        tuple_t t;
        int k;
        t.rd   = 5'($urandom);
        t.rs1  = 5'($urandom);
        t.rs2  = 5'($urandom);
        t.alu  = 4'($urandom);
        t.com  = 3'($urandom);
        t.sign = 1'($urandom);
        k = $urandom_range(0, 15);
        case (k)
            0, 1, 2:  t.ty = T_IMM;
            3, 4:     t.ty = T_REG;
            5:        t.ty = T_UPP;
            6:        t.ty = T_JUMP;
            7:        t.ty = T_JUMPR;
            8, 9:     t.ty = T_BRANCH;
            10, 11:   t.ty = 5'd8 + 5'($urandom_range(0, 3));
            12:       t.ty = 5'd12 + 5'($urandom_range(0, 3));
            13, 14:   t.ty = 5'd16 + 5'($urandom_range(0, 7));
            default:  t.ty = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd24 + 5'($urandom_range(0, 7));
        endcase
        case ($urandom_range(0, 5))
            0:       t.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1:       t.imm = $urandom;
            2:       t.imm = 32'($urandom_range(0, 31));
            3:       t.imm = $urandom & 32'hFFFF_F000;
            4:       t.imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
            default: t.imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
        endcase
        return t;
    endfunction

    // Offers one tuple starting at the next falling edge and holds it until
    // accepted; returns just after the accepting rising edge.
    task automatic applyStimulus(input tuple_t t);
        int waitCycles;
        bit done;
        logic [32:0] exp;
        @(negedge clock);
        in_type = t.ty; in_rd = t.rd; in_rs1 = t.rs1; in_rs2 = t.rs2;
        in_imm = t.imm; in_alu_op = t.alu; in_com_op = t.com; in_mem_sign = t.sign;
        in_valid = 1'b1;
        waitCycles = 0;
        done = 1'b0;
        exp = refEncode(t);
        while (!done) begin
            checkOutput("inReady", 64'(in_ready), 64'(expQ.size() < DEPTH));
            if (in_ready) begin
                expQ.push_back(exp);
                done = 1'b1;
            end else if (waitCycles >= 100) begin
                checkOutput("acceptTimeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end else begin
                @(negedge clock);
                waitCycles++;
            end
        end
        @(posedge clock);
        modelEnc++;
        if (exp[32]) modelErr++;
        #1 in_valid = 1'b0;
    endtask

    task automatic directed(input tuple_t t, input logic [31:0] expInst, input logic expErr);
        applyStimulus(t);
        checkOutput("dirValid", 64'(out_valid), 64'd1);
        checkOutput("dirInst", 64'(out_inst), 64'(expInst));
        checkOutput("dirErr", 64'(out_err), 64'(expErr));
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || out_valid) && n < 500) begin
            @(negedge clock);
            #2;
            n++;
        end
        checkOutput("drainQueue", 64'(expQ.size()), 64'd0);
        checkOutput("drainValid", 64'(out_valid), 64'd0);
    endtask

    task automatic checkCounters();
        checkOutput("encCount", 64'(enc_count), 64'(CNT_W'(modelEnc)));
        checkOutput("errCount", 64'(err_count), 64'(CNT_W'(modelErr)));
    endtask

    // Monitor: drives out_ready per readyMode, compares the head whenever it
    // is valid and retires the expected entry on transfer.
    initial begin
        forever begin
            @(negedge clock);
            case (readyMode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                2:       out_ready = 1'($urandom);
                default: out_ready = ~out_ready;
            endcase
            #1;
            if (reset_n && out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousOut", 64'(out_valid), 64'd0);
                end else begin
                    checkOutput("head", 64'({out_err, out_inst}), 64'(expQ[0]));
                    if (out_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tuple_t t5;
        // Reset state
        repeat (3) @(negedge clock);
        checkOutput("rstValid", 64'(out_valid), 64'd0);
        checkOutput("rstInst", 64'(out_inst), 64'd0);
        checkOutput("rstErr", 64'(out_err), 64'd0);
        checkOutput("rstInReady", 64'(in_ready), 64'd0);
        checkCounters();
        #2 reset_n = 1'b1;
        #1 checkOutput("releaseInReady", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1 checkOutput("liveInReady", 64'(in_ready), 64'd1);

        // Directed encodings
        readyMode = 1;
        directed(mk(T_IMM, 5'd1, 5'd0, 5'd0, 32'd5, 4'b0000, 3'd0, 1'b0), 32'h0050_0093, 1'b0);
        directed(mk(T_IMM, 5'd2, 5'd1, 5'd0, 32'd3, 4'b1101, 3'd0, 1'b0), 32'h4030_D113, 1'b0);
        directed(mk(T_IMM, 5'd2, 5'd1, 5'd0, 32'd32, 4'b1101, 3'd0, 1'b0), 32'h0000_0013, 1'b1);
        directed(mk(T_UPP, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 4'd0, 3'd0, 1'b0), 32'h1234_52B7, 1'b0);
        directed(mk(T_BRANCH, 5'd0, 5'd1, 5'd2, 32'd3, 4'd0, 3'd0, 1'b0), 32'h0000_0013, 1'b1);
        waitDrain();
        checkCounters();

        // Fill with consumer stalled; fifth tuple must be held until drained
        readyMode = 0;
        repeat (4) applyStimulus(randTuple());
        t5 = randTuple();
        fork
            applyStimulus(t5);
            begin
                repeat (3) @(negedge clock);
                #1;
                checkOutput("fullInReady", 64'(in_ready), 64'd0);
                checkOutput("fullValid", 64'(out_valid), 64'd1);
                readyMode = 1;
            end
        join
        waitDrain();
        checkCounters();

        // Back-to-back stream against a consumer toggling every cycle
        readyMode = 3;
        repeat (40) applyStimulus(randTuple());
        waitDrain();
        checkCounters();

        // Random stream with random gaps and random backpressure
        readyMode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clock);
            applyStimulus(randTuple());
        end
        readyMode = 1;
        waitDrain();
        checkCounters();

        // Asynchronous reset with entries buffered
        readyMode = 0;
        repeat (3) applyStimulus(randTuple());
        @(negedge clock);
        #3 reset_n = 1'b0;
        #1;
        checkOutput("midRstValid", 64'(out_valid), 64'd0);
        checkOutput("midRstInReady", 64'(in_ready), 64'd0);
        expQ.delete();
        modelEnc = 0;
        modelErr = 0;
        checkCounters();
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        #1 checkOutput("midRelInReady", 64'(in_ready), 64'd0);
        readyMode = 1;
        applyStimulus(randTuple());
        checkOutput("postRstValid", 64'(out_valid), 64'd1);
        waitDrain();
        checkCounters();
        checkOutput("postRstEnc", 64'(enc_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/inst_enc.md
Name: inst_enc

Overview:
RV32I instruction encoder. It takes decoded-form instruction fields (the same inst_type, alu_op, com_op and is_mem_sign encodings the core decoder produces) and packs them into 32-bit instruction words. Results are buffered in a small FIFO with valid/ready on both sides. It serves the self-test/boot-image generator and the trace re-encoder.

Parameters:
DEPTH, 4, output FIFO entries (power of 2, >=2)
CNT_W, 16, width of the encoded and error counters

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  field tuple valid
in_ready  out  1  encoder can accept a tuple this cycle
in_type  in  INST_TYPE_END+1  instruction class (INST_* encoding from defs.vh)
in_rd  in  REG_END_ID+1  destination register
in_rs1  in  REG_END_ID+1  source register 1
in_rs2  in  REG_END_ID+1  source register 2
in_imm  in  REG_END_WORD+1  full sign-extended immediate (byte offset for jumps/branches)
in_alu_op  in  4  {sub/sra bit, funct3} for IMM/REG
in_com_op  in  3  branch funct3
in_mem_sign  in  1  load sign (1 = signed)
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes the head
out_inst  out  REG_END_WORD+1  encoded instruction
out_err  out  1  head entry was unencodable
enc_count  out  CNT_W  tuples accepted (wraps)
err_count  out  CNT_W  tuples flagged in error (wraps)

Behaviour:
- Reset (async, reset_n=0): FIFO empty, out_valid=0, out_inst=0, out_err=0, both counters 0, in_ready=0 while reset is asserted and 1 on the first clock after release.
- Reset mid-operation flushes all buffered entries. No partial output.
- Accept: in_valid & in_ready at edge N. Encoding is combinational, the write happens at edge N. The entry appears at the head with out_valid=1 after edge N if the FIFO was empty (1-cycle latency).
- in_ready = (count != DEPTH). A pop in the same cycle does not free space for a push when full.
- Pop: out_valid & out_ready. Push and pop in the same cycle at 0<count<DEPTH leaves count unchanged.
- out_inst and out_err are registered FIFO head outputs. They stay stable while out_valid & !out_ready.
- Encoding by in_type (opcode from defs.vh OPCODE_*):
  - IMM: funct3=alu_op[2:0], I-format. For funct3 001/101, inst[31:25]={1'b0,alu_op[3],5'b0} and shamt=imm[4:0]. Error if shift and imm[31:5]!=0, or non-shift and imm not in [-2048,2047], or alu_op[3] set with funct3!=101.
  - REG: R-format, inst[30]=alu_op[3]. Error if alu_op[3] set and funct3 not in {000,101}.
  - LOAD {010,sz}: funct3={~mem_sign,sz}. Error if sz==11, or sz==10 with mem_sign=0. I-format immediate range check.
  - STORE {011,sz}: funct3={0,sz}, S-format. Error if sz==11 or imm out of 12-bit range.
  - UPP: U-format imm[31:12]. Error if imm[11:0]!=0.
  - JUMP: J-format. Error if imm[0]!=0 or imm not in 21-bit signed range.
  - JUMPR: I-format, funct3=000, range check.
  - BRANCH: B-format, funct3=com_op. Error if com_op in {010,011}, imm[0]!=0, or imm not in 13-bit signed range.
  - SYSTEM {10,f3}: I-format with imm[11:0] as CSR address, funct3=f3, opcode SYSTEM. Error if f3==000 or f3==100.
  - Any other in_type is an error.
- Error entries are still pushed, with out_inst=32'h0000_0013 (NOP) and out_err=1. err_count increments.
- enc_count increments on every accept. Both counters wrap at 2^CNT_W. No saturation.

Decomposition:
- Opcode, INST_*, ALU_OP_*, COM_OP_*, FUNCT3_* constants come from shared defs.vh. Add there: the NOP word and the immediate-range localparams.
- One sub-module: inst_fifo, a synchronous DEPTH x (REG_END_WORD+2) FIFO with count/full/empty, async active-low reset, registered head.
- Format packing and error checks live in the top as a single always_comb.

Test Plan:
- IMM rd=1 rs1=0 alu_op=0000 imm=5 -> out_inst=0x00500093, out_err=0, out_valid one cycle after accept, enc_count=1.
- IMM rd=2 rs1=1 alu_op=1101 imm=3 -> 0x4030D113. Same with imm=32 -> 0x00000013, out_err=1, err_count=1.
- UPP rd=5 imm=0x12345000 -> 0x123452B7. BRANCH com_op=000 imm=3 -> NOP, out_err=1.
- DEPTH=4, out_ready=0, drive 5 back-to-back tuples -> in_ready low after the 4th accept, 5th held. Raise out_ready -> all 5 emitted in order, no loss or duplication.
- Continuous stream with out_ready toggling every cycle -> count never exceeds DEPTH, head stable while stalled.
- Assert reset_n low with 3 entries buffered -> out_valid=0 and counters 0 immediately (asynchronously). After release the first new tuple emerges alone.
